// File: rtl/cbus_mem_responder_if.sv
// cbus_if: initiator/responder request and response signals of the cbus.
interface cbus_if;
  logic        req_valid;
  logic        req_is_write;
  logic [2:0]  req_size;
  logic [63:0] req_addr;
  logic [7:0]  req_strobe;
  logic [63:0] req_data;
  logic [7:0]  req_len;
  logic [1:0]  req_burst;
  logic        resp_ready;
  logic        resp_last;
  logic [63:0] resp_data;
  modport master (
    output req_valid, req_is_write, req_size, req_addr, req_strobe, req_data, req_len, req_burst,
    input  resp_ready, resp_last, resp_data
  );
  modport slave (
    input  req_valid, req_is_write, req_size, req_addr, req_strobe, req_data, req_len, req_burst,
    output resp_ready, resp_last, resp_data
  );
endinterface

// File: rtl/cbus_mem_responder.sv
// cbus_mem_responder: word-addressed 64-bit backing memory answering cbus requests
// with configurable latency, byte-strobed writes and FIXED/INCR bursts.
module cbus_mem_responder #(
  parameter int          DEPTH     = 1024,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int          LATENCY   = 2
) (
  input  logic  clk,
  input  logic  rst,
  cbus_if.slave cbus,
  output logic  err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] BURST_FIXED = 2'd0;
  typedef enum logic [2:0] {IDLE, WAIT, BEAT, GAP, GAP_END} state_t;
  state_t      state_q, state_d;
  logic        is_write_q, is_write_d;
  logic [63:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d, beat_q, beat_d, lat_q, lat_d;
  logic [1:0]  burst_q, burst_d;
  logic        err_q, err_d;
  logic [63:0] mem [DEPTH];
  logic [63:0] off, req_off;
  logic        hit, req_hit, we;
  logic [AW-1:0] idx;
  logic        unused_ok;
  // Subtracting the base lets addresses below it wrap high and fail the range test.
  assign off     = addr_q - BASE_ADDR;
  assign req_off = cbus.req_addr - BASE_ADDR;
  assign hit     = off[63:AW+3] == '0;
  assign req_hit = req_off[63:AW+3] == '0;
  assign idx     = off[AW+2:3];
  assign err_o   = err_q;
  assign unused_ok = ^{cbus.req_size, off[2:0], req_off[AW+2:0]};
  always_ff @(posedge clk) begin
    if (we)
      for (int i = 0; i < 8; i++)
        if (cbus.req_strobe[i]) mem[idx][8*i +: 8] <= cbus.req_data[8*i +: 8];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      lat_q      <= '0;
      burst_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      lat_q      <= lat_d;
      burst_q    <= burst_d;
      err_q      <= err_d;
    end
  end
  always_comb begin
    state_d         = state_q;
    is_write_d      = is_write_q;
    addr_d          = addr_q;
    len_d           = len_q;
    beat_d          = beat_q;
    lat_d           = lat_q;
    burst_d         = burst_q;
    err_d           = err_q;
    we              = 1'b0;
    cbus.resp_ready = 1'b0;
    cbus.resp_last  = 1'b0;
    cbus.resp_data  = '0;
    case (state_q)
      IDLE: if (cbus.req_valid) begin
        is_write_d = cbus.req_is_write;
        addr_d     = cbus.req_addr;
        len_d      = cbus.req_len;
        burst_d    = cbus.req_burst;
        beat_d     = '0;
        lat_d      = 8'(LATENCY - 1);
        err_d      = err_q | ~req_hit;
        state_d    = WAIT;
      end
      WAIT: begin
        state_d = !cbus.req_valid ? IDLE : lat_q == '0 ? BEAT : WAIT;
        lat_d   = lat_q == '0 ? lat_q : lat_q - 8'd1;
      end
      BEAT: if (!cbus.req_valid) state_d = IDLE;
      else begin
        cbus.resp_ready = 1'b1;
        cbus.resp_last  = beat_q == len_q;
        cbus.resp_data  = (is_write_q || !hit) ? '0 : mem[idx];
        we              = is_write_q && hit;
        err_d           = err_q | ~hit;
        if (beat_q == len_q) state_d = GAP_END;
        else begin
          beat_d  = beat_q + 8'd1;
          addr_d  = burst_q == BURST_FIXED ? addr_q : addr_q + 64'd8;
          lat_d   = '0;
          state_d = GAP;
        end
      end
      GAP:     state_d = cbus.req_valid ? BEAT : IDLE;
      GAP_END: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cbus_mem_responder.sv
// tb_cbus_mem_responder: directed scenario tests of the cbus memory responder.
module tb_cbus_mem_responder;
  localparam logic [63:0] BASE = 64'h8000_0000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err;
  int   total = 0;
  int   bad = 0;
  cbus_if bus ();
  cbus_mem_responder dut (.clk(clk), .rst(rst), .cbus(bus), .err_o(err));
  always #5 clk = ~clk;
  task automatic idle_req();
    bus.req_valid = 1'b0; bus.req_is_write = 1'b0; bus.req_size = 3'd3; bus.req_addr = '0;
    bus.req_strobe = '0; bus.req_data = '0; bus.req_len = '0; bus.req_burst = 2'd1;
  endtask
  task automatic txn(input logic wr, input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                     output logic [63:0] rd, output logic lst, output int cyc);
    bus.req_valid = 1'b1; bus.req_is_write = wr; bus.req_addr = a; bus.req_data = d;
    bus.req_strobe = s; bus.req_len = 8'd0; bus.req_burst = 2'd1;
    rd = '0; lst = 1'b0; cyc = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.resp_ready) begin rd = bus.resp_data; lst = bus.resp_last; break; end
      cyc++;
    end
    if (cyc == 30) begin total++; bad++; $display("FAIL txn_timeout addr=%h got no ready want ready", a); end
    @(posedge clk); #1;
    idle_req();
    @(posedge clk); #1;
  endtask
  task automatic run_burst(input logic [63:0] a, input logic [7:0] len, input logic [1:0] burst,
                           output logic [63:0] d [8], output logic l [8], output int n, output logic glued);
    logic prev = 1'b0;
    n = 0; glued = 1'b0;
    for (int i = 0; i < 8; i++) begin d[i] = '0; l[i] = 1'b0; end
    bus.req_valid = 1'b1; bus.req_is_write = 1'b0; bus.req_addr = a; bus.req_len = len; bus.req_burst = burst;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.resp_ready) begin
        if (prev) glued = 1'b1;
        if (n < 8) begin d[n] = bus.resp_data; l[n] = bus.resp_last; end
        n++;
        if (bus.resp_last) break;
      end
      prev = bus.resp_ready;
    end
    @(posedge clk); #1;
    idle_req();
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    @(negedge clk);
    total++; if (bus.resp_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", bus.resp_ready); end
    total++; if (bus.resp_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b want=0", bus.resp_last); end
    total++; if (bus.resp_data !== 64'd0) begin bad++; $display("FAIL reset_data got=%h want=0", bus.resp_data); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic test_read_latency();
    logic [63:0] rd; logic lst; int cyc;
    txn(1'b1, BASE + 64'h10, 64'hDEAD_BEEF, 8'hFF, rd, lst, cyc);
    bus.req_valid = 1'b1; bus.req_is_write = 1'b0; bus.req_addr = BASE + 64'h10; bus.req_len = 8'd0;
    cyc = 0; rd = '0; lst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.resp_ready) begin rd = bus.resp_data; lst = bus.resp_last; break; end
      cyc++;
    end
    total++; if (cyc !== 3) begin bad++; $display("FAIL lat_cycles got=%0d want=3", cyc); end
    total++; if (rd !== 64'hDEAD_BEEF) begin bad++; $display("FAIL lat_data got=%h want=deadbeef", rd); end
    total++; if (lst !== 1'b1) begin bad++; $display("FAIL lat_last got=%b want=1", lst); end
    @(negedge clk);
    total++; if (bus.resp_ready !== 1'b0) begin bad++; $display("FAIL lat_ready_drop got=%b want=0", bus.resp_ready); end
    @(posedge clk); #1;
    idle_req();
    @(posedge clk); #1;
  endtask
  task automatic test_strobe_write();
    logic [63:0] rd; logic lst; int cyc;
    txn(1'b1, BASE + 64'h18, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, lst, cyc);
    txn(1'b1, BASE + 64'h18, 64'h1122_3344_5566_7788, 8'h0F, rd, lst, cyc);
    total++; if (rd !== 64'd0) begin bad++; $display("FAIL write_resp_data got=%h want=0", rd); end
    total++; if (lst !== 1'b1) begin bad++; $display("FAIL write_last got=%b want=1", lst); end
    txn(1'b0, BASE + 64'h18, 64'd0, 8'h00, rd, lst, cyc);
    total++; if (rd !== 64'hFFFF_FFFF_5566_7788) begin bad++; $display("FAIL strobe_readback got=%h want=ffffffff55667788", rd); end
  endtask
  task automatic test_burst();
    logic [63:0] rd; logic lst; int cyc; logic [63:0] d [8]; logic l [8]; int n; logic glued;
    for (int i = 0; i < 4; i++) txn(1'b1, BASE + 64'(8 * i), 64'hA000 + 64'(i), 8'hFF, rd, lst, cyc);
    run_burst(BASE, 8'd3, 2'd1, d, l, n, glued);
    total++; if (n !== 4) begin bad++; $display("FAIL incr_beats got=%0d want=4", n); end
    total++; if (glued !== 1'b0) begin bad++; $display("FAIL incr_pulse_width got=%b want=0", glued); end
    for (int i = 0; i < 4; i++) begin
      total++; if (d[i] !== 64'hA000 + 64'(i)) begin bad++; $display("FAIL incr_data%0d got=%h want=%h", i, d[i], 64'hA000 + 64'(i)); end
      total++; if (l[i] !== (i == 3)) begin bad++; $display("FAIL incr_last%0d got=%b want=%b", i, l[i], i == 3); end
    end
    run_burst(BASE + 64'h8, 8'd1, 2'd0, d, l, n, glued);
    total++; if (n !== 2) begin bad++; $display("FAIL fixed_beats got=%0d want=2", n); end
    total++; if (d[0] !== 64'hA001 || d[1] !== 64'hA001) begin bad++; $display("FAIL fixed_data got=%h,%h want=a001,a001", d[0], d[1]); end
  endtask
  task automatic test_back_to_back();
    logic [63:0] rd, r1, r2; logic lst; int cyc; logic early;
    txn(1'b1, BASE + 64'h28, 64'h5555_0005, 8'hFF, rd, lst, cyc);
    txn(1'b1, BASE + 64'h30, 64'h6666_0006, 8'hFF, rd, lst, cyc);
    bus.req_valid = 1'b1; bus.req_is_write = 1'b0; bus.req_addr = BASE + 64'h28; bus.req_len = 8'd0;
    r1 = '0; r2 = '0; cyc = 0; early = 1'b0;
    for (int i = 0; i < 30; i++) begin @(negedge clk); if (bus.resp_ready) begin r1 = bus.resp_data; break; end end
    @(posedge clk); #1;
    bus.req_addr = BASE + 64'h30;
    @(negedge clk);
    early = bus.resp_ready;
    for (int i = 0; i < 30; i++) begin @(negedge clk); if (bus.resp_ready) begin r2 = bus.resp_data; break; end cyc++; end
    total++; if (r1 !== 64'h5555_0005) begin bad++; $display("FAIL chain_first got=%h want=55550005", r1); end
    total++; if (early !== 1'b0) begin bad++; $display("FAIL chain_gap_ready got=%b want=0", early); end
    total++; if (r2 !== 64'h6666_0006) begin bad++; $display("FAIL chain_second got=%h want=66660006", r2); end
    total++; if (cyc !== 3) begin bad++; $display("FAIL chain_latency got=%0d want=3", cyc); end
    @(posedge clk); #1;
    idle_req();
    @(posedge clk); #1;
  endtask
  task automatic test_out_of_range();
    logic [63:0] rd; logic lst; int cyc; logic [63:0] d [8]; logic l [8]; int n; logic glued;
    txn(1'b1, BASE + 64'h1FF8, 64'hCAFE_F00D, 8'hFF, rd, lst, cyc);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clean got=%b want=0", err); end
    run_burst(BASE + 64'h1FF8, 8'd1, 2'd1, d, l, n, glued);
    total++; if (n !== 2 || d[0] !== 64'hCAFE_F00D || d[1] !== 64'd0) begin
      bad++; $display("FAIL cross_top got=%0d:%h,%h want=2:cafef00d,0", n, d[0], d[1]); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL cross_err got=%b want=1", err); end
    txn(1'b0, 64'h0, 64'd0, 8'h00, rd, lst, cyc);
    total++; if (rd !== 64'd0 || lst !== 1'b1) begin bad++; $display("FAIL oor_read got=%h/%b want=0/1", rd, lst); end
    txn(1'b1, BASE - 64'h8, 64'h1234, 8'hFF, rd, lst, cyc);
    txn(1'b0, BASE + 64'h1FF8, 64'd0, 8'h00, rd, lst, cyc);
    total++; if (rd !== 64'hCAFE_F00D) begin bad++; $display("FAIL oor_write_dropped got=%h want=cafef00d", rd); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", err); end
  endtask
  task automatic test_abort();
    logic [63:0] rd; logic lst; int cyc;
    txn(1'b1, BASE + 64'h40, 64'h0BAD_0000_1111, 8'hFF, rd, lst, cyc);
    bus.req_valid = 1'b1; bus.req_is_write = 1'b1; bus.req_addr = BASE + 64'h40;
    bus.req_data = 64'h7777; bus.req_strobe = 8'hFF;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    total++; if ({bus.resp_ready, bus.resp_last, bus.resp_data} !== 66'd0) begin
      bad++; $display("FAIL rst_resp got=%b/%b/%h want=0/0/0", bus.resp_ready, bus.resp_last, bus.resp_data); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", err); end
    @(posedge clk); #1;
    rst = 1'b0;
    idle_req();
    @(posedge clk); #1;
    txn(1'b0, BASE + 64'h40, 64'd0, 8'h00, rd, lst, cyc);
    total++; if (rd !== 64'h0BAD_0000_1111) begin bad++; $display("FAIL rst_no_write got=%h want=0bad00001111", rd); end
    total++; if (cyc !== 3) begin bad++; $display("FAIL rst_next_req got=%0d want=3", cyc); end
    bus.req_valid = 1'b1; bus.req_is_write = 1'b1; bus.req_addr = BASE + 64'h40;
    bus.req_data = 64'h8888; bus.req_strobe = 8'hFF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    idle_req();
    txn(1'b0, BASE + 64'h40, 64'd0, 8'h00, rd, lst, cyc);
    total++; if (rd !== 64'h0BAD_0000_1111) begin bad++; $display("FAIL drop_valid_no_write got=%h want=0bad00001111", rd); end
  endtask
  initial begin
    idle_req();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_read_latency();
    test_strobe_write();
    test_burst();
    test_back_to_back();
    test_out_of_range();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
